// File: rtl/pulse_meter.sv
//==============================================================================
// Module      : pulse_meter
// Description : Measures high width, period and pulse count of an asynchronous
//               signal. Results go out through a valid/ack handshake with
//               sticky overrun/overflow flags. Optional glitch filter is
//               built in when PULSE_METER_GLITCH_FILTER_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pulse_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int GLITCH_CYC  = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  input  logic             meas_ack,
  output logic             meas_valid,
  output logic [CNT_W-1:0] width,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] pulse_count,
  output logic             overrun,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] c_MAX = '1;
  localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sig_s;
  logic                   w_sig_f;
  logic                   r_sig_d;
  logic                   w_rise;
  logic                   w_fall;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_pcnt;
  logic [CNT_W-1:0]       w_pcnt_nxt;
  logic [CNT_W-1:0]       w_pcnt_inc;
  logic [CNT_W-1:0]       r_wlat;
  logic [CNT_W-1:0]       w_wlat_nxt;
  logic                   w_pcnt_sat;
  logic                   w_pcnt_ovf;
  logic                   w_count_pulse;
  logic                   w_publish;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
    end
  end

  assign w_sig_s = r_sync[SYNC_STAGES-1];

`ifdef PULSE_METER_GLITCH_FILTER_EN
  localparam int c_GW = $clog2(GLITCH_CYC + 1);

  logic [c_GW-1:0] r_gcnt;
  logic            r_sig_f;

  // Filtered level follows sig_s only after GLITCH_CYC consecutive differing cycles
  always_ff @(posedge clock) begin
    if (reset) begin
      r_gcnt  <= '0;
      r_sig_f <= 1'b0;
    end else if (w_sig_s == r_sig_f) begin
      r_gcnt  <= '0;
    end else if (r_gcnt == c_GW'(GLITCH_CYC - 1)) begin
      r_gcnt  <= '0;
      r_sig_f <= w_sig_s;
    end else begin
      r_gcnt  <= r_gcnt + 1'b1;
    end
  end

  assign w_sig_f = r_sig_f;
`else
  // GLITCH_CYC has no effect without the filter; referenced to keep it live
  assign w_sig_f = (GLITCH_CYC >= 0) ? w_sig_s : 1'b0;
`endif

  assign w_rise = w_sig_f & ~r_sig_d;
  assign w_fall = ~w_sig_f & r_sig_d;

  assign w_pcnt_sat = (r_pcnt == c_MAX);
  assign w_pcnt_inc = w_pcnt_sat ? r_pcnt : r_pcnt + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pcnt_nxt    = r_pcnt;
    w_wlat_nxt    = r_wlat;
    w_count_pulse = 1'b0;
    w_publish     = 1'b0;
    w_pcnt_ovf    = 1'b0;
    if (!enable) begin
      w_state_nxt = S_IDLE;
      w_pcnt_nxt  = '0;
      w_wlat_nxt  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            w_state_nxt   = S_HIGH;
            w_pcnt_nxt    = c_ONE;
            w_count_pulse = 1'b1;
          end
        end
        S_HIGH: begin
          w_pcnt_nxt = w_pcnt_inc;
          w_pcnt_ovf = w_pcnt_sat;
          if (w_fall) begin
            w_wlat_nxt  = r_pcnt;
            w_state_nxt = S_LOW;
          end
        end
        S_LOW: begin
          if (w_rise) begin
            w_publish     = 1'b1;
            w_pcnt_nxt    = c_ONE;
            w_count_pulse = 1'b1;
            w_state_nxt   = S_HIGH;
          end else begin
            w_pcnt_nxt = w_pcnt_inc;
            w_pcnt_ovf = w_pcnt_sat;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_pcnt_nxt  = '0;
          w_wlat_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sig_d     <= 1'b0;
      r_pcnt      <= '0;
      r_wlat      <= '0;
      meas_valid  <= 1'b0;
      width       <= '0;
      period      <= '0;
      pulse_count <= '0;
      overrun     <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      r_sig_d <= w_sig_f;
      r_pcnt  <= w_pcnt_nxt;
      r_wlat  <= w_wlat_nxt;

      if (w_count_pulse) begin
        if (pulse_count == c_MAX) begin
          overflow <= 1'b1;
        end else begin
          pulse_count <= pulse_count + 1'b1;
        end
      end

      if (w_pcnt_ovf) begin
        overflow <= 1'b1;
      end

      // A same-cycle ack frees the slot, so the new result replaces the old one
      if (w_publish) begin
        if (!meas_valid || meas_ack) begin
          width      <= r_wlat;
          period     <= r_pcnt;
          meas_valid <= 1'b1;
        end else begin
          overrun    <= 1'b1;
        end
      end else if (meas_ack) begin
        meas_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pulse_meter.sv
//==============================================================================
// Module      : tb_pulse_meter
// Description : Directed, table-driven bench for pulse_meter (CNT_W=16 and 4).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pulse_meter;

`ifdef PULSE_METER_GLITCH_FILTER_EN
  localparam int LAT = 3 + 3;
`else
  localparam int LAT = 3;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        sig_in = 1'b0;
  logic        meas_ack = 1'b0;

  logic        meas_valid;
  logic [15:0] width;
  logic [15:0] period;
  logic [15:0] pulse_count;
  logic        overrun;
  logic        overflow;

  logic        meas_valid4;
  logic [3:0]  width4;
  logic [3:0]  period4;
  logic [3:0]  pulse_count4;
  logic        overrun4;
  logic        overflow4;

  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  pulse_meter #(.CNT_W(16), .SYNC_STAGES(2), .GLITCH_CYC(3)) u_dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .sig_in      (sig_in),
    .meas_ack    (meas_ack),
    .meas_valid  (meas_valid),
    .width       (width),
    .period      (period),
    .pulse_count (pulse_count),
    .overrun     (overrun),
    .overflow    (overflow)
  );

  pulse_meter #(.CNT_W(4), .SYNC_STAGES(2), .GLITCH_CYC(3)) u_dut4 (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .sig_in      (sig_in),
    .meas_ack    (meas_ack),
    .meas_valid  (meas_valid4),
    .width       (width4),
    .period      (period4),
    .pulse_count (pulse_count4),
    .overrun     (overrun4),
    .overflow    (overflow4)
  );

  typedef struct {
    int hi;
    int lo;
    bit ack;
    bit e_valid;
    int e_w;
    int e_p;
    int e_pc;
    bit e_ovr;
  } vec_t;

  vec_t vecs[8];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    sig_in   = 1'b0;
    enable   = 1'b0;
    meas_ack = 1'b0;
    reset    = 1'b1;
    tick(2);
    reset    = 1'b0;
    tick(1);
    enable   = 1'b1;
    tick(LAT + 2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int used;

    // {hi, lo, ack, expected valid/width/period/count/overrun at the rise starting this row}
    vecs[0] = '{12, 12, 1'b1, 1'b0,  0,  0, 1, 1'b0};
    vecs[1] = '{12, 12, 1'b1, 1'b1, 12, 24, 2, 1'b0};
    vecs[2] = '{ 7,  7, 1'b1, 1'b1, 12, 24, 3, 1'b0};
    vecs[3] = '{12, 12, 1'b1, 1'b1,  7, 14, 4, 1'b0};
    vecs[4] = '{ 6,  9, 1'b0, 1'b1, 12, 24, 5, 1'b0};
    vecs[5] = '{12, 12, 1'b0, 1'b1, 12, 24, 6, 1'b1};
    vecs[6] = '{ 8,  8, 1'b1, 1'b1, 12, 24, 7, 1'b1};
    vecs[7] = '{ 8,  4, 1'b1, 1'b1,  8, 16, 8, 1'b1};

    // Reset state
    tick(3);
    chk("rst_valid",    meas_valid,  0);
    chk("rst_width",    width,       0);
    chk("rst_period",   period,      0);
    chk("rst_count",    pulse_count, 0);
    chk("rst_overrun",  overrun,     0);
    chk("rst_overflow", overflow,    0);

    // Table-driven periodic waveforms
    do_reset();
    sig_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(LAT);
      chk($sformatf("v%0d_valid", i),   meas_valid,  32'(vecs[i].e_valid));
      chk($sformatf("v%0d_width", i),   width,       vecs[i].e_w);
      chk($sformatf("v%0d_period", i),  period,      vecs[i].e_p);
      chk($sformatf("v%0d_count", i),   pulse_count, vecs[i].e_pc);
      chk($sformatf("v%0d_overrun", i), overrun,     32'(vecs[i].e_ovr));
      chk($sformatf("v%0d_overflow", i), overflow,   0);
      used = LAT;
      if (vecs[i].ack) begin
        meas_ack = 1'b1;
        tick(1);
        meas_ack = 1'b0;
        chk($sformatf("v%0d_valid_after_ack", i), meas_valid, 0);
        used++;
      end
      tick(vecs[i].hi - used);
      sig_in = 1'b0;
      tick(vecs[i].lo);
      sig_in = 1'b1;
    end

    // Ack in the exact publish cycle
    do_reset();
    sig_in = 1'b1; tick(10);
    sig_in = 1'b0; tick(10);
    sig_in = 1'b1; tick(LAT);
    chk("same_ack_first_valid", meas_valid, 1);
    chk("same_ack_first_width", width, 10);
    chk("same_ack_first_period", period, 20);
    tick(12 - LAT);
    sig_in = 1'b0; tick(9);
    sig_in = 1'b1; tick(LAT - 1);
    meas_ack = 1'b1;
    tick(1);
    meas_ack = 1'b0;
    chk("same_ack_valid",   meas_valid, 1);
    chk("same_ack_width",   width, 12);
    chk("same_ack_period",  period, 21);
    chk("same_ack_overrun", overrun, 0);
    tick(1);
    chk("same_ack_valid_hold", meas_valid, 1);

    // Counter saturation on the 4-bit instance
    do_reset();
    sig_in = 1'b1; tick(20);
    sig_in = 1'b0; tick(5);
    sig_in = 1'b1; tick(LAT);
    chk("sat4_valid",    meas_valid4, 1);
    chk("sat4_width",    width4, 15);
    chk("sat4_period",   period4, 15);
    chk("sat4_overflow", overflow4, 1);
    chk("sat4_count",    pulse_count4, 2);
    chk("sat16_width",   width, 20);
    chk("sat16_period",  period, 25);
    chk("sat16_overflow", overflow, 0);

    // Enable dropped mid-HIGH, re-raised with the line high
    do_reset();
    sig_in = 1'b1; tick(8);
    enable = 1'b0; tick(2);
    chk("dis_count_hold", pulse_count, 1);
    chk("dis_valid", meas_valid, 0);
    enable = 1'b1; tick(5);
    sig_in = 1'b0; tick(6);
    sig_in = 1'b1; tick(LAT);
    chk("reen_first_rise_valid", meas_valid, 0);
    chk("reen_first_rise_count", pulse_count, 2);
    chk("reen_first_rise_width", width, 0);
    tick(8 - LAT);
    sig_in = 1'b0; tick(8);
    sig_in = 1'b1; tick(LAT);
    chk("reen_valid",  meas_valid, 1);
    chk("reen_width",  width, 8);
    chk("reen_period", period, 16);
    chk("reen_count",  pulse_count, 3);
    tick(8 - LAT);
    sig_in = 1'b0; tick(LAT + 3);
    reset = 1'b1; tick(1);
    chk("midrst_valid",  meas_valid, 0);
    chk("midrst_width",  width, 0);
    chk("midrst_period", period, 0);
    chk("midrst_count",  pulse_count, 0);
    chk("midrst_overrun", overrun, 0);
    reset = 1'b0;

    // Short glitch
    do_reset();
    sig_in = 1'b1; tick(2);
    sig_in = 1'b0; tick(10);
`ifdef PULSE_METER_GLITCH_FILTER_EN
    chk("glitch_count", pulse_count, 0);
    sig_in = 1'b1; tick(10);
    sig_in = 1'b0; tick(10);
    sig_in = 1'b1; tick(LAT);
    chk("filt_width",  width, 10);
    chk("filt_period", period, 20);
    chk("filt_count",  pulse_count, 2);
`else
    chk("glitch_count", pulse_count, 1);
    meas_ack = 1'b1;
    sig_in = 1'b1; tick(1);
    sig_in = 1'b0; tick(5);
    sig_in = 1'b1; tick(LAT);
    chk("one_cyc_width",  width, 1);
    chk("one_cyc_period", period, 6);
    chk("one_cyc_count",  pulse_count, 3);
    meas_ack = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
